// File: rtl/in_register_port.sv
// Input register port: captures a nibble over an async four-phase strobe/ack handshake
// and presents it on the OR-merged internal bus on ReadIn. Build option: INREG_OVERWRITE_EN.
module in_register_port #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              MainClock,
    input  logic              MainReset,
    input  logic [DATA_W-1:0] InData,
    input  logic              InStrobe,
    output logic              InAck,
    input  logic              ReadIn,
    output logic [DATA_W-1:0] IB,
    output logic              IBDrive,
    output logic              Full,
    output logic              Overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t            state;
    logic              s1;
    logic              s2;
    logic [DATA_W-1:0] hold;
    logic              capture_ok;

    // Default build stalls the device while unread data is held.
`ifdef INREG_OVERWRITE_EN
    assign capture_ok = 1'b1;
`else
    assign capture_ok = ~Full;
`endif

    // Read path; reset forces the bus quiet even if a stale Full is still set.
    assign IBDrive = ReadIn & Full & ~MainReset;
    assign IB      = IBDrive ? hold : '0;

    // Synchronizer, holding register and handshake FSM.
    always_ff @(posedge MainClock) begin
        if (MainReset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            hold  <= '0;
            Full  <= 1'b0;
            InAck <= 1'b0;
            state <= IDLE;
        end else begin
            s1 <= InStrobe;
            s2 <= s1;
            if (IBDrive) begin
                Full <= 1'b0;
            end
            // Capture comes after the read clear so a same-cycle capture keeps Full set.
            case (state)
                IDLE: begin
                    if (s2 && capture_ok) begin
                        hold  <= InData;
                        Full  <= 1'b1;
                        InAck <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!s2) begin
                        InAck <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    InAck <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INREG_OVERWRITE_EN
    logic overrun_q;

    // Sticky: set when unread data is overwritten without a concurrent read.
    always_ff @(posedge MainClock) begin
        if (MainReset) begin
            overrun_q <= 1'b0;
        end else if (state == IDLE && s2 && Full && !ReadIn) begin
            overrun_q <= 1'b1;
        end
    end

    assign Overrun = overrun_q;
`else
    assign Overrun = 1'b0;
`endif

endmodule

// File: tb/tb_in_register_port.sv
// Self-checking bench for in_register_port; read data is checked against a scoreboard queue.
module tb_in_register_port;

    localparam int unsigned DATA_W = 4;

    logic              MainClock = 1'b0;
    logic              MainReset;
    logic [DATA_W-1:0] InData;
    logic              InStrobe;
    logic              InAck;
    logic              ReadIn;
    logic [DATA_W-1:0] IB;
    logic              IBDrive;
    logic              Full;
    logic              Overrun;

    int unsigned       n_cmp = 0;
    int unsigned       n_bad = 0;
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] exp_d;

    in_register_port #(.DATA_W(DATA_W)) dut (
        .MainClock(MainClock),
        .MainReset(MainReset),
        .InData(InData),
        .InStrobe(InStrobe),
        .InAck(InAck),
        .ReadIn(ReadIn),
        .IB(IB),
        .IBDrive(IBDrive),
        .Full(Full),
        .Overrun(Overrun)
    );

    always #5 MainClock = ~MainClock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge MainClock);
    endtask

    function automatic logic [DATA_W-1:0] sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        MainReset = 1'b1; InStrobe = 1'b0; ReadIn = 1'b0; InData = '0;
        tick(2);
        #1;
        n_cmp++;
        if ({InAck, Full, IBDrive, IB, Overrun} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 0", {InAck, Full, IBDrive, IB, Overrun});
        end
        MainReset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ReadIn = i[0];
            InData = DATA_W'(i);
            #1;
            n_cmp++;
            if ({InAck, Full, IBDrive, IB, Overrun} !== '0) begin
                n_bad++;
                $display("FAIL idle_%0d: got %b want 0", i, {InAck, Full, IBDrive, IB, Overrun});
            end
            tick(1);
        end
        ReadIn = 1'b0;
    endtask

    task automatic test_capture_read();
        InData = 4'hA; InStrobe = 1'b1;
        tick(2); #1;
        n_cmp++;
        if (InAck !== 1'b0) begin
            n_bad++; $display("FAIL cap_early: got InAck=%b want 0", InAck);
        end
        tick(1); #1;
        n_cmp++;
        if ({InAck, Full} !== 2'b11) begin
            n_bad++; $display("FAIL cap_e2: got InAck,Full=%b want 11", {InAck, Full});
        end
        sb.push_back(4'hA);
        InStrobe = 1'b0;
        tick(2); #1;
        n_cmp++;
        if (InAck !== 1'b1) begin
            n_bad++; $display("FAIL ack_hold: got InAck=%b want 1", InAck);
        end
        tick(1); #1;
        n_cmp++;
        if (InAck !== 1'b0) begin
            n_bad++; $display("FAIL ack_drop: got InAck=%b want 0", InAck);
        end
        ReadIn = 1'b1; #1;
        exp_d = sb_pop();
        n_cmp++;
        if ({IBDrive, IB} !== {1'b1, exp_d}) begin
            n_bad++; $display("FAIL read_a: got drive=%b ib=%h want 1 %h", IBDrive, IB, exp_d);
        end
        tick(1); ReadIn = 1'b0; #1;
        n_cmp++;
        if ({Full, IBDrive, IB} !== '0) begin
            n_bad++; $display("FAIL read_a_clear: got %b want 0", {Full, IBDrive, IB});
        end
    endtask

`ifndef INREG_OVERWRITE_EN
    task automatic test_backpressure();
        int k;
        InData = 4'h3; InStrobe = 1'b1;
        tick(3);
        sb.push_back(4'h3);
        InStrobe = 1'b0;
        tick(3);
        InData = 4'h5; InStrobe = 1'b1;
        tick(4); #1;
        n_cmp++;
        if ({InAck, Full} !== 2'b01) begin
            n_bad++; $display("FAIL bp_stall: got InAck,Full=%b want 01", {InAck, Full});
        end
        ReadIn = 1'b1; #1;
        exp_d = sb_pop();
        n_cmp++;
        if ({IBDrive, IB} !== {1'b1, exp_d}) begin
            n_bad++; $display("FAIL bp_read_old: got drive=%b ib=%h want 1 %h", IBDrive, IB, exp_d);
        end
        tick(1); ReadIn = 1'b0;
        k = 0;
        while (InAck !== 1'b1 && k < 2) begin
            tick(1); k++;
        end
        #1;
        n_cmp++;
        if ({InAck, Full} !== 2'b11) begin
            n_bad++; $display("FAIL bp_recapture: got InAck,Full=%b want 11", {InAck, Full});
        end
        sb.push_back(4'h5);
        InStrobe = 1'b0;
        tick(3);
        ReadIn = 1'b1; #1;
        exp_d = sb_pop();
        n_cmp++;
        if ({IBDrive, IB} !== {1'b1, exp_d}) begin
            n_bad++; $display("FAIL bp_read_new: got drive=%b ib=%h want 1 %h", IBDrive, IB, exp_d);
        end
        tick(1); ReadIn = 1'b0;
    endtask
`endif

    task automatic test_read_hold();
        InData = 4'hC; InStrobe = 1'b1;
        tick(3);
        sb.push_back(4'hC);
        InStrobe = 1'b0;
        tick(3);
        ReadIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_d = (i == 0) ? sb_pop() : '0;
            n_cmp++;
            if ({IBDrive, IB} !== {(i == 0), exp_d}) begin
                n_bad++;
                $display("FAIL hold_read_%0d: got drive=%b ib=%h want %b %h", i, IBDrive, IB, (i == 0), exp_d);
            end
            tick(1);
        end
        ReadIn = 1'b0;
    endtask

    task automatic test_reset_mid();
        InData = 4'h7; InStrobe = 1'b1;
        tick(3); #1;
        n_cmp++;
        if (InAck !== 1'b1) begin
            n_bad++; $display("FAIL rm_ack: got InAck=%b want 1", InAck);
        end
        MainReset = 1'b1; ReadIn = 1'b1; #1;
        n_cmp++;
        if ({IBDrive, IB} !== '0) begin
            n_bad++; $display("FAIL rm_bus: got drive=%b ib=%h want 0 0", IBDrive, IB);
        end
        tick(1); ReadIn = 1'b0; #1;
        n_cmp++;
        if ({InAck, Full} !== 2'b00) begin
            n_bad++; $display("FAIL rm_cleared: got InAck,Full=%b want 00", {InAck, Full});
        end
        MainReset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1); #1;
            n_cmp++;
            if (InAck !== 1'b0) begin
                n_bad++; $display("FAIL rm_refill_%0d: got InAck=%b want 0", i, InAck);
            end
        end
        tick(1); #1;
        n_cmp++;
        if ({InAck, Full} !== 2'b11) begin
            n_bad++; $display("FAIL rm_recapture: got InAck,Full=%b want 11", {InAck, Full});
        end
        sb.push_back(4'h7);
        InStrobe = 1'b0;
        tick(3);
        ReadIn = 1'b1; #1;
        exp_d = sb_pop();
        n_cmp++;
        if ({IBDrive, IB} !== {1'b1, exp_d}) begin
            n_bad++; $display("FAIL rm_read: got drive=%b ib=%h want 1 %h", IBDrive, IB, exp_d);
        end
        tick(1); ReadIn = 1'b0;
    endtask

`ifdef INREG_OVERWRITE_EN
    task automatic test_overwrite();
        MainReset = 1'b1; tick(1); MainReset = 1'b0; sb.delete();
        InData = 4'h1; InStrobe = 1'b1; tick(3); InStrobe = 1'b0; tick(3);
        InData = 4'h2; InStrobe = 1'b1; tick(3); #1;
        n_cmp++;
        if ({InAck, Full, Overrun} !== 3'b111) begin
            n_bad++; $display("FAIL ow_capture: got InAck,Full,Overrun=%b want 111", {InAck, Full, Overrun});
        end
        sb.push_back(4'h2);
        InStrobe = 1'b0; tick(3);
        ReadIn = 1'b1; #1;
        exp_d = sb_pop();
        n_cmp++;
        if ({IBDrive, IB} !== {1'b1, exp_d}) begin
            n_bad++; $display("FAIL ow_read: got drive=%b ib=%h want 1 %h", IBDrive, IB, exp_d);
        end
        tick(1); ReadIn = 1'b0; #1;
        n_cmp++;
        if ({Full, Overrun} !== 2'b01) begin
            n_bad++; $display("FAIL ow_sticky: got Full,Overrun=%b want 01", {Full, Overrun});
        end
        MainReset = 1'b1; tick(1); MainReset = 1'b0;
        InData = 4'h1; InStrobe = 1'b1; tick(3); InStrobe = 1'b0; tick(3);
        sb.push_back(4'h1);
        InData = 4'h2; InStrobe = 1'b1; tick(2);
        ReadIn = 1'b1; #1;
        exp_d = sb_pop();
        n_cmp++;
        if ({IBDrive, IB} !== {1'b1, exp_d}) begin
            n_bad++; $display("FAIL ow_same_read: got drive=%b ib=%h want 1 %h", IBDrive, IB, exp_d);
        end
        tick(1); ReadIn = 1'b0; #1;
        n_cmp++;
        if ({InAck, Full, Overrun} !== 3'b110) begin
            n_bad++; $display("FAIL ow_same_cap: got InAck,Full,Overrun=%b want 110", {InAck, Full, Overrun});
        end
        sb.push_back(4'h2);
        InStrobe = 1'b0; tick(3);
        ReadIn = 1'b1; #1;
        exp_d = sb_pop();
        n_cmp++;
        if ({IBDrive, IB} !== {1'b1, exp_d}) begin
            n_bad++; $display("FAIL ow_same_new: got drive=%b ib=%h want 1 %h", IBDrive, IB, exp_d);
        end
        tick(1); ReadIn = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_capture_read();
`ifndef INREG_OVERWRITE_EN
        test_backpressure();
`endif
        test_read_hold();
        test_reset_mid();
`ifdef INREG_OVERWRITE_EN
        test_overwrite();
`endif
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
